// File: rtl/btn_arb_pkg.sv
// State encoding shared by the button/LED arbiter and its bench.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package btn_arb_pkg;

  localparam logic [1:0] ENC_IDLE   = 2'b00;
  localparam logic [1:0] ENC_GRANT0 = 2'b01;
  localparam logic [1:0] ENC_GRANT1 = 2'b10;
  localparam logic [1:0] ENC_CHORD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = ENC_IDLE,
    ST_GRANT0 = ENC_GRANT0,
    ST_GRANT1 = ENC_GRANT1,
    ST_CHORD  = ENC_CHORD
  } arb_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus level debouncer for one raw button.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples before req follows the button.
// Backpressure: none; req is a level, sampled freely by the consumer.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic req
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // cnt holds the number of differing samples already seen; the sample that
  // would make it DEBOUNCE_CYCLES flips req instead, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      cnt  <= '0;
      req  <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      if (sync == req) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        req <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_led_arbiter.sv
// Two-button arbiter for a shared LED with minimum hold time; BTN_ARB_CHORD_EN adds a both-LED chord state.
// Latency: debounced request to LED in 1 cycle; grant held at least HOLD_CYCLES cycles.
// Backpressure: none; a losing request simply waits until the current grant may be released.
module btn_led_arbiter
  import btn_arb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic btn0,
  input  logic btn1,
  output logic led0,
  output logic led1
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic          req0;
  logic          req1;
  arb_state_t    state;
  arb_state_t    nxt;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  logic          last_grant;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
    .clk (clk),
    .rst (rst),
    .btn (btn0),
    .req (req0)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
    .clk (clk),
    .rst (rst),
    .btn (btn1),
    .req (req1)
  );

  // hold_cnt reads k after the k-th edge of a grant, so the grant may end on
  // the edge where it would reach HOLD_CYCLES: exactly HOLD_CYCLES LED cycles.
  assign hold_done = (hold_cnt >= HOLD_LAST);

`ifdef BTN_ARB_CHORD_EN
  logic req0_q;
  logic req1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req0_q <= 1'b0;
      req1_q <= 1'b0;
    end else begin
      req0_q <= req0;
      req1_q <= req1;
    end
  end
`endif

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (req0 && req1) begin
          nxt = last_grant ? ST_GRANT0 : ST_GRANT1;
        end else if (req0) begin
          nxt = ST_GRANT0;
        end else if (req1) begin
          nxt = ST_GRANT1;
        end
`ifdef BTN_ARB_CHORD_EN
        if (req0 && req1 && !req0_q && !req1_q) begin
          nxt = ST_CHORD;
        end
`endif
      end
      ST_GRANT0: begin
        if (hold_done) begin
          if (req1) begin
            nxt = ST_GRANT1;
          end else if (!req0) begin
            nxt = ST_IDLE;
          end
        end
      end
      ST_GRANT1: begin
        if (hold_done) begin
          if (req0) begin
            nxt = ST_GRANT0;
          end else if (!req1) begin
            nxt = ST_IDLE;
          end
        end
      end
      ST_CHORD: begin
`ifdef BTN_ARB_CHORD_EN
        if (!req0 || !req1) begin
          nxt = ST_IDLE;
        end
`else
        nxt = ST_IDLE;
`endif
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      led0       <= 1'b0;
      led1       <= 1'b0;
      hold_cnt   <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= nxt;
      led0  <= (nxt == ST_GRANT0) || (nxt == ST_CHORD);
      led1  <= (nxt == ST_GRANT1) || (nxt == ST_CHORD);
      if (nxt != state) begin
        hold_cnt <= '0;
      end else if ((state == ST_GRANT0 || state == ST_GRANT1) && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (nxt == ST_GRANT0 && state != ST_GRANT0) begin
        last_grant <= 1'b0;
      end
      if (nxt == ST_GRANT1 && state != ST_GRANT1) begin
        last_grant <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btn_led_arbiter.sv
// Directed vector bench for btn_led_arbiter at DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
// Latency: n/a. Backpressure: n/a.
// Inputs change and outputs are compared on the falling clock edge.
module tb_btn_led_arbiter;

  logic clk;
  logic rst;
  logic btn0;
  logic btn1;
  logic led0;
  logic led1;

  int nvec;
  int nmis;

  btn_led_arbiter #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .btn0 (btn0),
    .btn1 (btn1),
    .led0 (led0),
    .led1 (led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp is {led1, led0}
  typedef struct {
    logic       b0;
    logic       b1;
    int         steps;
    logic       every;
    logic [1:0] exp;
  } vec_t;

  vec_t tv[17];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [1:0] exp);
    nvec++;
    if ({led1, led0} !== exp) begin
      nmis++;
      $display("FAIL %s: leds{1,0}=%b expected %b at %0t", nm, {led1, led0}, exp, $time);
    end
  endtask

  task automatic do_reset();
    btn0 = 1'b0;
    btn1 = 1'b0;
    rst  = 1'b1;
    step();
    step();
    chk("reset_hold", 2'b00);
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: leds{1,0}=%b expected bench to finish", {led1, led0});
    $fatal(1, "watchdog");
  end

  initial begin
    nvec = 0;
    nmis = 0;
    btn0 = 1'b0;
    btn1 = 1'b0;
    rst  = 1'b1;

    tv[0]  = '{1'b0, 1'b0,  2, 1'b1, 2'b00};  // idle
    tv[1]  = '{1'b1, 1'b0,  3, 1'b1, 2'b00};  // 3-cycle glitch on btn0
    tv[2]  = '{1'b0, 1'b0,  6, 1'b1, 2'b00};  // glitch must not pass
    tv[3]  = '{1'b1, 1'b0,  6, 1'b1, 2'b00};  // press btn0: 6 edges quiet
    tv[4]  = '{1'b1, 1'b0,  1, 1'b0, 2'b01};  // led0 on the 7th edge
    tv[5]  = '{1'b0, 1'b0,  7, 1'b1, 2'b01};  // released: hold keeps grant
    tv[6]  = '{1'b0, 1'b0,  1, 1'b0, 2'b00};  // 8 LED cycles then idle
    tv[7]  = '{1'b0, 1'b1,  6, 1'b1, 2'b00};  // press btn1
    tv[8]  = '{1'b0, 1'b1,  1, 1'b0, 2'b10};
    tv[9]  = '{1'b1, 1'b1,  7, 1'b1, 2'b10};  // btn0 joins during hold
    tv[10] = '{1'b1, 1'b1,  1, 1'b0, 2'b01};  // direct switch after 8
    tv[11] = '{1'b1, 1'b1,  7, 1'b1, 2'b01};
    tv[12] = '{1'b1, 1'b1,  1, 1'b0, 2'b10};  // switch back
    tv[13] = '{1'b0, 1'b1, 12, 1'b1, 2'b10};  // btn1 alone keeps grant
    tv[14] = '{1'b0, 1'b0,  6, 1'b1, 2'b10};  // release: debounce delay
    tv[15] = '{1'b0, 1'b0,  1, 1'b0, 2'b00};
    tv[16] = '{1'b0, 1'b0,  3, 1'b1, 2'b00};

    // reset state, checked before any clock edge
    #1;
    chk("reset_async", 2'b00);
    @(negedge clk);
    step();
    chk("reset_clocked", 2'b00);
    rst = 1'b0;
    step();

    for (int i = 0; i < 17; i++) begin
      btn0 = tv[i].b0;
      btn1 = tv[i].b1;
      for (int s = 1; s <= tv[i].steps; s++) begin
        step();
        if (tv[i].every || s == tv[i].steps) begin
          chk($sformatf("vec%0d_step%0d", i, s), tv[i].exp);
        end
      end
    end

    // simultaneous press from fresh reset
    do_reset();
    btn0 = 1'b1;
    btn1 = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      step();
      chk($sformatf("tie_wait%0d", s), 2'b00);
    end
    step();
`ifdef BTN_ARB_CHORD_EN
    chk("chord_on", 2'b11);
    btn1 = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      step();
      chk($sformatf("chord_hold%0d", s), 2'b11);
    end
    step();
    chk("chord_off", 2'b00);
    step();
    chk("chord_then_g0", 2'b01);
`else
    chk("tie_led0_first", 2'b01);
    for (int s = 1; s <= 7; s++) begin
      step();
      chk($sformatf("tie_g0_hold%0d", s), 2'b01);
    end
    step();
    chk("tie_led1_after8", 2'b10);
`endif

    // btn0 released in the third hold cycle
    do_reset();
    btn0 = 1'b1;
    repeat (7) step();
    chk("rel3_grant", 2'b01);
    step();
    step();
    btn0 = 1'b0;
    for (int s = 3; s <= 8; s++) begin
      step();
      chk($sformatf("rel3_hold%0d", s), 2'b01);
    end
    step();
    chk("rel3_idle", 2'b00);

    // asynchronous reset in the middle of a GRANT1
    do_reset();
    btn1 = 1'b1;
    repeat (7) step();
    chk("rst_mid_grant1", 2'b10);
    repeat (3) step();
    chk("rst_mid_still", 2'b10);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_drop", 2'b00);
    @(negedge clk);
    step();
    chk("rst_mid_held", 2'b00);
    rst = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      step();
      chk($sformatf("rst_rearb_wait%0d", s), 2'b00);
    end
    step();
    chk("rst_rearb_led1", 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
